msg_stage_reg: RTL and testbench

- Pipeline register that produces the packed per-stage message bus consumed by the field splitter of the next stage (D/E, E/M and M/W boundaries).
- Latches the upstream bus each cycle and supports hold (stall), bubble insertion (flush) and global exception/interrupt clear (req).
- On each transfer it ages the hazard field Tnew and merges a locally detected exception code.
- One instance per stage boundary; field positions are set by parameters.

---
 rtl/msg_stage_reg.sv | 159 +++++++++++++++
 tb/tb_msg_stage_reg.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/msg_stage_reg.sv
// ---------------------------------------------------------------------------
// msg_stage_reg
//   Pipeline register for one stage boundary (D/E, E/M or M/W). It captures
//   the packed message bus from the upstream stage and feeds the downstream
//   field splitter. Each transfer ages the Tnew hazard field and merges a
//   locally detected exception code. The register also supports hold
//   (stall), bubble insertion (flush) and a global exception clear (req).
//
//   Priority on each clock edge: req > stall > flush > load.
//
// Ports
//   clk        : clock; all state changes on the rising edge
//   reset      : asynchronous, active-high reset
//   stall      : hold the current contents
//   flush      : insert a bubble (the PC and BD bit are kept for the EPC)
//   req        : exception/interrupt clear; loads HANDLER_PC
//   exc_in     : exception code detected upstream (0 = none)
//   msg_in     : upstream message bus, W bits
//   msg_out    : registered message bus, W bits
//   valid_out  : 1 = real instruction, 0 = bubble
//   stall_cnt  : saturating count of stall cycles (optional)
//   bubble_cnt : saturating count of inserted bubbles (optional)
//
// Optional feature
//   Define MSG_STAGE_STAT_EN to build the two statistics counters. When the
//   macro is not defined, both counter outputs are tied to zero. The port
//   list is the same in both builds.
// ---------------------------------------------------------------------------
module msg_stage_reg #(
  parameter int          W          = 160,
  parameter int          PC_LSB     = 0,
  parameter int          TNEW_LSB   = 32,
  parameter int          EXC_LSB    = 36,
  parameter int          BD_BIT     = 41,
  parameter logic [31:0] HANDLER_PC = 32'h0000_4180
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          stall,
  input  logic          flush,
  input  logic          req,
  input  logic [4:0]    exc_in,
  input  logic [W-1:0]  msg_in,
  output logic [W-1:0]  msg_out,
  output logic          valid_out,
  output logic [15:0]   stall_cnt,
  output logic [15:0]   bubble_cnt
);

  // Returns 1 when the field [lo, lo+w) lies inside the W-bit bus.
  function automatic bit f_in_bus(input int lo, input int w);
    return (lo >= 0) && (lo + w <= W);
  endfunction

  // Returns 1 when the fields [a_lo, a_lo+a_w) and [b_lo, b_lo+b_w) do not overlap.
  function automatic bit f_disjoint(input int a_lo, input int a_w,
                                    input int b_lo, input int b_w);
    return (a_lo + a_w <= b_lo) || (b_lo + b_w <= a_lo);
  endfunction

  localparam bit P_OK =
    f_in_bus(PC_LSB, 32) && f_in_bus(TNEW_LSB, 4) &&
    f_in_bus(EXC_LSB, 5) && f_in_bus(BD_BIT, 1) &&
    f_disjoint(PC_LSB, 32, TNEW_LSB, 4) && f_disjoint(PC_LSB, 32, EXC_LSB, 5) &&
    f_disjoint(PC_LSB, 32, BD_BIT, 1)   && f_disjoint(TNEW_LSB, 4, EXC_LSB, 5) &&
    f_disjoint(TNEW_LSB, 4, BD_BIT, 1)  && f_disjoint(EXC_LSB, 5, BD_BIT, 1);

  generate
    if (!P_OK) begin : g_param_err
      $error("msg_stage_reg: field ranges exceed W or overlap");
    end
  endgenerate

  localparam logic [W-1:0] L_RESET_MSG   = W'(32'h0000_3000) << PC_LSB;
  localparam logic [W-1:0] L_HANDLER_MSG = W'(HANDLER_PC) << PC_LSB;

  logic [W-1:0] r_msg;
  logic         r_valid;
  logic [W-1:0] w_next_msg;
  logic         w_next_valid;
  logic [3:0]   w_tnew_in;
  logic [4:0]   w_exc_in_msg;

  assign w_tnew_in    = msg_in[TNEW_LSB +: 4];
  assign w_exc_in_msg = msg_in[EXC_LSB +: 5];

  // Next-state selection in priority order req > stall > flush > load.
  always_comb begin
    w_next_msg   = r_msg;
    w_next_valid = r_valid;
    if (req) begin
      w_next_msg   = L_HANDLER_MSG;
      w_next_valid = 1'b0;
    end else if (stall) begin
      // Hold: Tnew is not aged while the stage is frozen.
      w_next_msg   = r_msg;
      w_next_valid = r_valid;
    end else if (flush) begin
      // Bubble keeps PC and BD so that a later exception reports the right EPC.
      w_next_msg                  = {W{1'b0}};
      w_next_msg[PC_LSB +: 32]    = msg_in[PC_LSB +: 32];
      w_next_msg[BD_BIT]          = msg_in[BD_BIT];
      w_next_valid                = 1'b0;
    end else begin
      w_next_msg                  = msg_in;
      // Tnew saturates at zero rather than wrapping to 4'hF.
      w_next_msg[TNEW_LSB +: 4]   = (w_tnew_in == 4'd0) ? 4'd0 : (w_tnew_in - 4'd1);
      // An older exception already on the bus wins over the local one.
      w_next_msg[EXC_LSB +: 5]    = (w_exc_in_msg != 5'd0) ? w_exc_in_msg : exc_in;
      w_next_valid                = 1'b1;
    end
  end

  // Message and valid registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_msg   <= L_RESET_MSG;
      r_valid <= 1'b0;
    end else begin
      r_msg   <= w_next_msg;
      r_valid <= w_next_valid;
    end
  end

  assign msg_out   = r_msg;
  assign valid_out = r_valid;

`ifdef MSG_STAGE_STAT_EN
  logic [15:0] r_stall_cnt;
  logic [15:0] r_bubble_cnt;
  logic        w_stall_taken;
  logic        w_flush_taken;

  assign w_stall_taken = stall & ~req;
  assign w_flush_taken = flush & ~stall & ~req;

  // Saturating statistics counters; they are cleared only by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stall_cnt  <= 16'd0;
      r_bubble_cnt <= 16'd0;
    end else begin
      if (w_stall_taken && (r_stall_cnt != 16'hFFFF)) begin
        r_stall_cnt <= r_stall_cnt + 16'd1;
      end
      if (w_flush_taken && (r_bubble_cnt != 16'hFFFF)) begin
        r_bubble_cnt <= r_bubble_cnt + 16'd1;
      end
    end
  end

  assign stall_cnt  = r_stall_cnt;
  assign bubble_cnt = r_bubble_cnt;
`else
  assign stall_cnt  = 16'd0;
  assign bubble_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_msg_stage_reg.sv
// ---------------------------------------------------------------------------
// tb_msg_stage_reg
//   Directed, self-checking bench for msg_stage_reg with default parameters.
//   Expected outputs are pushed to a scoreboard queue when stimulus is driven
//   and popped after the capturing clock edge.
// ---------------------------------------------------------------------------
module tb_msg_stage_reg;

`ifdef MSG_STAGE_STAT_EN
  localparam bit STAT = 1'b1;
`else
  localparam bit STAT = 1'b0;
`endif

  logic         clk;
  logic         reset;
  logic         stall;
  logic         flush;
  logic         req;
  logic [4:0]   exc_in;
  logic [159:0] msg_in;
  logic [159:0] msg_out;
  logic         valid_out;
  logic [15:0]  stall_cnt;
  logic [15:0]  bubble_cnt;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [159:0] msg;
    logic         v;
    string        tag;
  } exp_t;

  exp_t sb_q[$];

  msg_stage_reg dut (
    .clk        (clk),
    .reset      (reset),
    .stall      (stall),
    .flush      (flush),
    .req        (req),
    .exc_in     (exc_in),
    .msg_in     (msg_in),
    .msg_out    (msg_out),
    .valid_out  (valid_out),
    .stall_cnt  (stall_cnt),
    .bubble_cnt (bubble_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Build a bus from explicit field values laid over a background pattern.
  function automatic logic [159:0] mk(input logic [31:0] pc, input logic [3:0] tn,
                                      input logic [4:0] ex, input logic bd,
                                      input logic [159:0] rest);
    logic [159:0] m;
    m        = rest;
    m[31:0]  = pc;
    m[35:32] = tn;
    m[40:36] = ex;
    m[41]    = bd;
    return m;
  endfunction

  task automatic chk_msg(input string tag, input logic [159:0] exp_m, input logic exp_v);
    checks++;
    assert (msg_out === exp_m) else begin
      errors++;
      $error("FAIL %s msg_out got %h exp %h", tag, msg_out, exp_m);
    end
    checks++;
    assert (valid_out === exp_v) else begin
      errors++;
      $error("FAIL %s valid_out got %b exp %b", tag, valid_out, exp_v);
    end
  endtask

  task automatic chk_cnt(input string tag, input int exp_s, input int exp_b);
    logic [15:0] es;
    logic [15:0] eb;
    es = STAT ? 16'(exp_s) : 16'd0;
    eb = STAT ? 16'(exp_b) : 16'd0;
    checks++;
    assert (stall_cnt === es) else begin
      errors++;
      $error("FAIL %s stall_cnt got %0d exp %0d", tag, stall_cnt, es);
    end
    checks++;
    assert (bubble_cnt === eb) else begin
      errors++;
      $error("FAIL %s bubble_cnt got %0d exp %0d", tag, bubble_cnt, eb);
    end
  endtask

  // Drive one cycle of stimulus, queue its expectation, check after the edge.
  task automatic step(input string tag, input logic st, input logic fl, input logic rq,
                      input logic [4:0] ex, input logic [159:0] m,
                      input logic [159:0] exp_m, input logic exp_v);
    exp_t e;
    @(negedge clk);
    stall  = st;
    flush  = fl;
    req    = rq;
    exc_in = ex;
    msg_in = m;
    e.msg  = exp_m;
    e.v    = exp_v;
    e.tag  = tag;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s scoreboard empty", tag);
    end else begin
      e = sb_q.pop_front();
      chk_msg(e.tag, e.msg, e.v);
    end
  endtask

  logic [159:0] rest;
  logic [159:0] ones;
  logic [159:0] zero;
  logic [159:0] held;

  initial begin
    rest   = 160'h5A5A_1234_DEAD_BEEF_0F0F_F0F0_CAFE_BABE_7654_3210;
    ones   = {160{1'b1}};
    zero   = {160{1'b0}};
    reset  = 1'b1;
    stall  = 1'b0;
    flush  = 1'b0;
    req    = 1'b0;
    exc_in = 5'd0;
    msg_in = zero;

    #1;
    chk_msg("reset", mk(32'h0000_3000, 4'd0, 5'd0, 1'b0, zero), 1'b0);
    chk_cnt("reset_cnt", 0, 0);
    @(negedge clk);
    reset = 1'b0;

    // Load aging and exception merge.
    step("load_age", 1'b0, 1'b0, 1'b0, 5'd4, mk(32'h3004, 4'd2, 5'd0, 1'b0, rest),
         mk(32'h3004, 4'd1, 5'd4, 1'b0, rest), 1'b1);
    step("load_tnew0", 1'b0, 1'b0, 1'b0, 5'd0, mk(32'h3008, 4'd0, 5'd0, 1'b0, rest),
         mk(32'h3008, 4'd0, 5'd0, 1'b0, rest), 1'b1);
    step("exc_prec", 1'b0, 1'b0, 1'b0, 5'd4, mk(32'h300C, 4'd1, 5'd10, 1'b1, ~rest),
         mk(32'h300C, 4'd0, 5'd10, 1'b1, ~rest), 1'b1);

    // Stall hold for three cycles with msg_in changing.
    held = mk(32'h3010, 4'd2, 5'd0, 1'b0, rest);
    step("load_3010", 1'b0, 1'b0, 1'b0, 5'd0, mk(32'h3010, 4'd3, 5'd0, 1'b0, rest), held, 1'b1);
    step("stall1", 1'b1, 1'b0, 1'b0, 5'd3, mk(32'h3100, 4'd5, 5'd1, 1'b1, ones), held, 1'b1);
    step("stall2", 1'b1, 1'b0, 1'b0, 5'd2, mk(32'h3200, 4'd6, 5'd0, 1'b0, zero), held, 1'b1);
    step("stall3", 1'b1, 1'b0, 1'b0, 5'd1, mk(32'h3300, 4'd7, 5'd2, 1'b1, ~rest), held, 1'b1);
    chk_cnt("stall_cnt3", 3, 0);

    // Bubble keeps PC and BD only.
    step("flush", 1'b0, 1'b1, 1'b0, 5'd9, mk(32'h3020, 4'd2, 5'h1F, 1'b1, ones),
         mk(32'h3020, 4'd0, 5'd0, 1'b1, zero), 1'b0);
    chk_cnt("bubble_cnt1", 3, 1);

    // Stall wins over flush.
    held = mk(32'h3030, 4'd0, 5'd0, 1'b0, rest);
    step("load_3030", 1'b0, 1'b0, 1'b0, 5'd0, mk(32'h3030, 4'd0, 5'd0, 1'b0, rest), held, 1'b1);
    step("stall_flush", 1'b1, 1'b1, 1'b0, 5'd9, mk(32'h3020, 4'd2, 5'h1F, 1'b1, ones), held, 1'b1);
    chk_cnt("stall_flush_cnt", 4, 1);

    // Global clear overrides stall and flush.
    step("req", 1'b1, 1'b1, 1'b1, 5'd9, mk(32'h3020, 4'd2, 5'h1F, 1'b1, ones),
         mk(32'h0000_4180, 4'd0, 5'd0, 1'b0, zero), 1'b0);
    chk_cnt("req_cnt", 4, 1);

    // Asynchronous reset in the middle of a stall.
    step("load_3040", 1'b0, 1'b0, 1'b0, 5'd3, mk(32'h3040, 4'd1, 5'd0, 1'b0, rest),
         mk(32'h3040, 4'd0, 5'd3, 1'b0, rest), 1'b1);
    @(negedge clk);
    stall = 1'b1;
    #2;
    reset = 1'b1;
    #1;
    chk_msg("async_reset", mk(32'h0000_3000, 4'd0, 5'd0, 1'b0, zero), 1'b0);
    chk_cnt("async_reset_cnt", 0, 0);
    stall = 1'b0;
    #1;
    reset = 1'b0;

    step("load_after_reset", 1'b0, 1'b0, 1'b0, 5'd7, mk(32'h3050, 4'd2, 5'd0, 1'b1, rest),
         mk(32'h3050, 4'd1, 5'd7, 1'b1, rest), 1'b1);
    chk_cnt("post_reset_cnt", 0, 0);

    checks++;
    assert (sb_q.size() == 0) else begin
      errors++;
      $error("FAIL scoreboard_drain left %0d exp 0", sb_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
